branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 71 +++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Tagless bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// plus saturating counts of resolved branches and mispredictions.
module branch_predictor #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        BranchD,
  input  logic [31:0] PCD,
  input  logic        StallD,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic        TakenE,
  input  logic        PredE,
  output logic        BranchPredict,
  output logic        MispredictE,
  output logic [15:0] BranchCount,
  output logic [15:0] MissCount
);

  localparam int ENTRIES = 1 << IDX_W;

  // No handshake: UpdateE is a single-cycle strobe accepted on every edge, one update per
  // cycle; BranchD/BranchPredict are purely combinational and need no acknowledge.
  logic [1:0]       r_bht [ENTRIES];
  logic [15:0]      r_branch_count;
  logic [15:0]      r_miss_count;

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_unused;

  assign w_rd_idx = PCD[IDX_W+1:2];
  assign w_wr_idx = PCE[IDX_W+1:2];

  // Reads the registered table only, so a same-cycle update to this entry is not bypassed.
  assign BranchPredict = BranchD & r_bht[w_rd_idx][1];
  assign MispredictE   = UpdateE & (PredE ^ TakenE);
  assign BranchCount   = r_branch_count;
  assign MissCount     = r_miss_count;

  // StallD needs no action: holding PCD alone keeps the prediction stable.
  assign w_unused = ^{StallD, PCD[31:IDX_W+2], PCD[1:0], PCE[31:IDX_W+2], PCE[1:0]};

  assign w_ctr_cur = r_bht[w_wr_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (TakenE) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= INIT_CTR;
      r_branch_count <= 16'h0000;
      r_miss_count   <= 16'h0000;
    end else if (UpdateE) begin
      r_bht[w_wr_idx] <= w_ctr_next;
      if (r_branch_count != 16'hFFFF) r_branch_count <= r_branch_count + 16'h0001;
      if (MispredictE && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'h0001;
    end
  end

endmodule
